// File: rtl/op_packer_12.sv
// op_packer_12: collects 3-bit operands into groups of up to twelve lanes.
// Each completed group is presented with its packed lanes, the lane sum and
// the number of lanes written; a group closes on the twelfth lane or on
// in_last, whichever comes first.
//
// Handshake: a beat transfers on any rising edge where in_valid && in_ready;
// a completed group transfers on any rising edge where out_valid && out_ready.
// Once out_valid is raised, op_out/sum_out/lanes_out hold until the transfer.
// in_ready is low only while a completed group is waiting and not taken.
module op_packer_12 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [2:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] op_out,
    output logic [6:0]  sum_out,
    output logic [3:0]  lanes_out
);

    // Assembly state for the group currently being collected.
    logic [3:0]  cnt;
    logic [35:0] asm_reg;
    logic [6:0]  run_sum;

    // Combinational view of the current beat.
    logic        accept;
    logic        complete;
    logic [35:0] asm_next;
    logic [6:0]  sum_next;
    logic [3:0]  lanes_next;

    // A waiting group blocks input only when downstream is not taking it.
    assign in_ready = !(out_valid && !out_ready);

    // Decode the beat: where it lands, the updated sum, and whether it closes the group.
    always_comb begin
        accept     = in_valid && in_ready;
        complete   = accept && ((cnt == 4'd11) || in_last);
        asm_next   = asm_reg;
        sum_next   = run_sum + {4'b0000, in_data};
        lanes_next = cnt + 4'd1;
        for (int k = 0; k < 12; k++) begin
            if (cnt == 4'(k)) begin
                asm_next[3*k +: 3] = in_data;
            end
        end
    end

    // Assembly register, running sum and lane counter; all cleared when a group closes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= 4'd0;
            asm_reg <= 36'd0;
            run_sum <= 7'd0;
        end else if (complete) begin
            cnt     <= 4'd0;
            asm_reg <= 36'd0;
            run_sum <= 7'd0;
        end else if (accept) begin
            cnt     <= cnt + 4'd1;
            asm_reg <= asm_next;
            run_sum <= sum_next;
        end
    end

    // Output group registers: load on completion, otherwise hold (data is retained after transfer).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_out    <= 36'd0;
            sum_out   <= 7'd0;
            lanes_out <= 4'd0;
        end else if (complete) begin
            op_out    <= asm_next;
            sum_out   <= sum_next;
            lanes_out <= lanes_next;
        end
    end

    // out_valid: set by a completion (even in the same cycle as a transfer), cleared by a bare transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_op_packer_12.sv
// tb_op_packer_12: directed bench for op_packer_12. Stimulus pushes the
// hand-computed group it expects into exp_q; a monitor pops and compares on
// every output transfer.
module tb_op_packer_12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [2:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] op_out;
    logic [6:0]  sum_out;
    logic [3:0]  lanes_out;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls = 0;
    int cyc = 0;
    logic [46:0] exp_q[$];
    logic [46:0] mon_e;
    logic [6:0]  inv_s;

    op_packer_12 dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_out(op_out), .sum_out(sum_out), .lanes_out(lanes_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_push(input logic [35:0] op, input logic [6:0] s, input logic [3:0] l);
        exp_q.push_back({op, s, l});
    endtask

    // ---------------- driver tasks ----------------
    // Present one beat and return #1 after the edge that accepted it.
    task automatic beat(input logic [2:0] d, input logic l);
        int  t;
        bit  done;
        t = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done && t < 50) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else stalls++;
            @(posedge clk);
            #1;
            t++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 3'd0;
        in_last  = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_group: got %0h with empty expected queue", {op_out, sum_out, lanes_out});
            end else begin
                mon_e = exp_q.pop_front();
                check("group", {op_out, sum_out, lanes_out}, mon_e);
            end
        end
    end

    // sum_out must always match the fields of op_out while a group is presented.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            inv_s = 7'd0;
            for (int k = 0; k < 12; k++) inv_s = inv_s + {4'd0, op_out[3*k +: 3]};
            check("sum_invariant", {40'd0, sum_out}, {40'd0, inv_s});
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int c_first;
    int c_second;
    logic [35:0] held_op;

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        idle();
        #1;
        check("reset_out_valid", {46'd0, out_valid}, 47'd0);
        check("reset_outputs", {op_out, sum_out, lanes_out}, 47'd0);
        check("reset_in_ready", {46'd0, in_ready}, 47'd1);
        cycles(2);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(1);

        // Twelve 7s: full group, checked for one-cycle latency.
        exp_push(36'hFFFFFFFFF, 7'd84, 4'd12);
        for (int i = 0; i < 11; i++) beat(3'd7, 1'b0);
        check("latency_early", {46'd0, out_valid}, 47'd0);
        beat(3'd7, 1'b0);
        check("latency_valid", {46'd0, out_valid}, 47'd1);
        check("all_sevens", {op_out, sum_out, lanes_out}, {36'hFFFFFFFFF, 7'd84, 4'd12});
        idle();
        cycles(2);

        // Lane k gets k mod 8.
        exp_push(36'h688FAC688, 7'd34, 4'd12);
        for (int i = 0; i < 12; i++) beat(3'(i % 8), 1'b0);
        idle();
        cycles(2);

        // Short group closed by in_last, then a one-lane group must start at lane 0.
        exp_push(36'h0000036DB, 7'd15, 4'd5);
        for (int i = 0; i < 5; i++) beat(3'd3, (i == 4));
        exp_push(36'h000000005, 7'd5, 4'd1);
        beat(3'd5, 1'b1);
        idle();
        cycles(2);

        // in_last on lane 11 closes only one group.
        exp_push(36'h492492492, 7'd24, 4'd12);
        for (int i = 0; i < 12; i++) beat(3'd2, (i == 11));
        exp_push(36'h000000021, 7'd5, 4'd2);
        beat(3'd1, 1'b0);
        beat(3'd4, 1'b1);
        idle();
        cycles(2);

        // Backpressure: group held for 5 cycles while a beat is offered and must be ignored.
        out_ready = 1'b0;
        exp_push(36'h00000002E, 7'd11, 4'd2);
        beat(3'd6, 1'b0);
        beat(3'd5, 1'b1);
        in_valid = 1'b1;
        in_data  = 3'd7;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {46'd0, out_valid}, 47'd1);
            check("hold_in_ready", {46'd0, in_ready}, 47'd0);
            check("hold_data", {op_out, sum_out, lanes_out}, {36'h00000002E, 7'd11, 4'd2});
            @(posedge clk);
            #1;
        end
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {46'd0, in_ready}, 47'd1);
        @(posedge clk);
        #1;
        check("release_valid_clear", {46'd0, out_valid}, 47'd0);
        check("release_data_kept", {11'd0, op_out}, {11'd0, 36'h00000002E});
        exp_push(36'h000000001, 7'd1, 4'd1);
        beat(3'd1, 1'b1);
        idle();
        cycles(2);

        // Reset mid-group: outputs clear at once, partial group discarded.
        for (int i = 0; i < 6; i++) beat(3'd7, 1'b0);
        held_op = op_out;
        check("pre_reset_data", {11'd0, held_op}, {11'd0, 36'h000000001});
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 3'd7;
        in_last  = 1'b1;
        #1;
        check("async_reset_outputs", {op_out, sum_out, lanes_out}, 47'd0);
        check("async_reset_valid", {46'd0, out_valid}, 47'd0);
        check("reset_in_ready_mid", {46'd0, in_ready}, 47'd1);
        cycles(2);
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        cycles(1);
        exp_push(36'h249249249, 7'd12, 4'd12);
        for (int i = 0; i < 12; i++) beat(3'd1, 1'b0);
        idle();
        cycles(2);

        // 24 continuous beats: two groups, no stalls, completions 12 cycles apart.
        stalls = 0;
        exp_push(36'hB6DB6DB6D, 7'd60, 4'd12);
        exp_push(36'hDB6DB6DB6, 7'd72, 4'd12);
        for (int i = 0; i < 24; i++) begin
            beat((i < 12) ? 3'd5 : 3'd6, 1'b0);
            if (i == 11) begin
                c_first = cyc;
                check("stream_valid_1", {46'd0, out_valid}, 47'd1);
            end
            if (i == 23) begin
                c_second = cyc;
                check("stream_valid_2", {46'd0, out_valid}, 47'd1);
            end
        end
        idle();
        check("stream_no_stall", 47'(stalls), 47'd0);
        check("stream_spacing", 47'(c_second - c_first), 47'd12);
        cycles(3);

        check("queue_drained", 47'(exp_q.size()), 47'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
